// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Purpose  : SPI mode-0 target with 32x8 register file and local access port.
//            Define SPI_TARGET_AUTOINC_EN to auto-increment the address per byte.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_oe,
    input  logic [7:0] status,
    input  logic       loc_we,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_pulse,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Bits [1:0] form the synchronizer, bit [2] holds the previous synchronized value
    logic [2:0]  r_ss_sync;
    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_mosi_sync;

    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_active;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic [4:0]  w_next_addr;

    logic [7:0]  r_regs [32];
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic [2:0]  r_bitcnt;
    logic [4:0]  r_addr;
    logic        r_miso;
    logic        r_wr_pulse;
    logic [4:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_loc_rdata;

    // Synchronizers reset low so a transfer never starts from reset release alone
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ss_sync   <= 3'b000;
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
        end
    end

    assign w_ss_fall   = r_ss_sync[2] & ~r_ss_sync[1];
    assign w_ss_rise   = ~r_ss_sync[2] & r_ss_sync[1];
    assign w_active    = (r_state != IDLE) & ~r_ss_sync[1];
    assign w_sclk_rise = w_active & r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = w_active & ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_byte_done = w_sclk_rise & (r_bitcnt == 3'd7);
    assign w_byte      = {r_rx, r_mosi_sync[1]};

`ifdef SPI_TARGET_AUTOINC_EN
    assign w_next_addr = r_addr + 5'd1;
`else
    assign w_next_addr = r_addr;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_ss_rise) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_ss_fall) w_state_next = CMD;
                CMD:     if (w_byte_done) w_state_next = w_byte[1] ? WR : RD;
                default: w_state_next = r_state;
            endcase
        end
    end

    // MISO is pre-registered: each falling edge presents r_tx[7], so a byte loaded
    // on the 8th rising edge shows its MSB on the following falling edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rx       <= '0;
            r_tx       <= '0;
            r_bitcnt   <= '0;
            r_addr     <= '0;
            r_miso     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            if ((r_state == IDLE) && w_ss_fall) begin
                r_tx     <= {status[6:0], 1'b0};
                r_miso   <= status[7];
                r_rx     <= '0;
                r_bitcnt <= '0;
            end else if (w_sclk_rise) begin
                r_rx     <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
                if (w_byte_done) begin
                    case (r_state)
                        CMD: begin
                            r_addr <= w_byte[7:3];
                            if (!w_byte[1]) r_tx <= r_regs[w_byte[7:3]];
                        end
                        WR: begin
                            r_wr_pulse <= 1'b1;
                            r_wr_addr  <= r_addr;
                            r_wr_data  <= w_byte;
                            r_addr     <= w_next_addr;
                        end
                        RD: begin
                            r_tx   <= r_regs[w_next_addr];
                            r_addr <= w_next_addr;
                        end
                        default: ;
                    endcase
                end
            end else if (w_sclk_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

    // SPI commit is applied after the local write so it wins on an address clash
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_loc_rdata <= 8'h00;
        end else begin
            if (loc_we) r_regs[loc_addr] <= loc_wdata;
            if (r_wr_pulse) r_regs[r_wr_addr] <= r_wr_data;
            r_loc_rdata <= r_regs[loc_addr];
        end
    end

    assign MISO      = r_miso & ((r_state == CMD) || (r_state == RD));
    assign MISO_oe   = (r_state != IDLE);
    assign busy      = (r_state != IDLE);
    assign wr_pulse  = r_wr_pulse;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_rdata = r_loc_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Purpose  : Directed self-checking bench for spi_target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;
    localparam int HALF = 8;

`ifdef SPI_TARGET_AUTOINC_EN
    localparam logic [7:0] EXP_R31 = 8'h11;
    localparam logic [7:0] EXP_R0  = 8'h22;
`else
    localparam logic [7:0] EXP_R31 = 8'h22;
    localparam logic [7:0] EXP_R0  = 8'h00;
`endif

    logic       Clk       = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       SS_n      = 1'b1;
    logic       SCLK      = 1'b0;
    logic       MOSI      = 1'b0;
    logic [7:0] status    = 8'h3C;
    logic       loc_we    = 1'b0;
    logic [4:0] loc_addr  = 5'd0;
    logic [7:0] loc_wdata = 8'h00;
    logic       MISO;
    logic       MISO_oe;
    logic [7:0] loc_rdata;
    logic       wr_pulse;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         checks    = 0;
    int         errors    = 0;
    int         pulse_cnt = 0;
    logic [4:0] last_addr = 5'd0;
    logic [7:0] last_data = 8'h00;

    spi_target dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .MISO_oe   (MISO_oe),
        .status    (status),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #10 Clk = ~Clk;

    always @(negedge Clk) begin
        if (wr_pulse === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = tx[7-i];
            wait_clk(HALF);
            rx   = {rx[6:0], MISO};
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        SS_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge Clk);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge Clk);
        loc_we = 1'b0;
    endtask

    task automatic loc_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge Clk);
        loc_addr = a;
        @(negedge Clk);
        d = loc_rdata;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        wait_clk(3);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", MISO_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL reset_loc_rdata: got %h want 00", loc_rdata); end
        Reset_n = 1'b1;
        wait_clk(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        logic [7:0] rx;
        logic [7:0] d;
        int         pc0;
        pc0 = pulse_cnt;
        ss_low();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
        checks++; if (MISO_oe !== 1'b1) begin errors++; $display("FAIL wr_oe: got %b want 1", MISO_oe); end
        spi_byte(8'h52, rx);
        spi_byte(8'hA5, rx);
        ss_high();
        checks++; if (pulse_cnt - pc0 != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", pulse_cnt - pc0); end
        checks++; if (last_addr !== 5'd10) begin errors++; $display("FAIL wr_addr: got %0d want 10", last_addr); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL wr_data: got %h want a5", last_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy: got %b want 0", busy); end
        loc_read(5'd10, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wr_reg10: got %h want a5", d); end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        int         pc0;
        loc_write(5'd3, 8'h81);
        status = 8'h3C;
        pc0 = pulse_cnt;
        ss_low();
        spi_byte(8'h18, rx);
        checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL rd_status: got %h want 3c", rx); end
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'h81) begin errors++; $display("FAIL rd_data: got %h want 81", rx); end
        ss_high();
        checks++; if (pulse_cnt != pc0) begin errors++; $display("FAIL rd_no_pulse: got %0d want 0", pulse_cnt - pc0); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rd_idle_miso: got %b want 0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL rd_idle_oe: got %b want 0", MISO_oe); end
    endtask

    task automatic test_sclk_ignored();
        int pc0;
        pc0 = pulse_cnt;
        MOSI = 1'b1;
        for (int i = 0; i < 16; i++) begin
            SCLK = 1'b1; wait_clk(HALF);
            SCLK = 1'b0; wait_clk(HALF);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy); end
        checks++; if (pulse_cnt != pc0) begin errors++; $display("FAIL ign_pulse: got %0d want 0", pulse_cnt - pc0); end
    endtask

    task automatic test_burst();
        logic [7:0] rx;
        logic [7:0] d;
        int         pc0;
        pc0 = pulse_cnt;
        ss_low();
        spi_byte(8'hFA, rx);
        spi_byte(8'h11, rx);
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL burst_miso_wr: got %h want 00", rx); end
        spi_byte(8'h22, rx);
        ss_high();
        checks++; if (pulse_cnt - pc0 != 2) begin errors++; $display("FAIL burst_pulses: got %0d want 2", pulse_cnt - pc0); end
        loc_read(5'd31, d);
        checks++; if (d !== EXP_R31) begin errors++; $display("FAIL burst_reg31: got %h want %h", d, EXP_R31); end
        loc_read(5'd0, d);
        checks++; if (d !== EXP_R0) begin errors++; $display("FAIL burst_reg0: got %h want %h", d, EXP_R0); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic [7:0] d;
        int         pc0;
        loc_write(5'd1, 8'h5A);
        pc0 = pulse_cnt;
        ss_low();
        spi_byte(8'h0A, rx);
        spi_bits(8'hFF, 5, rx);
        ss_high();
        checks++; if (pulse_cnt != pc0) begin errors++; $display("FAIL abort_pulse: got %0d want 0", pulse_cnt - pc0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", MISO_oe); end
        loc_read(5'd1, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL abort_reg1: got %h want 5a", d); end
    endtask

    // Writes spi_val to reg[7] over SPI while a local write of 0x99 to la lands on the commit cycle
    task automatic collide(input logic [4:0] la, input logic [7:0] spi_val);
        logic [7:0] rx;
        logic       found;
        found = 1'b0;
        fork
            begin
                ss_low();
                spi_byte(8'h3A, rx);
                spi_byte(spi_val, rx);
                ss_high();
            end
            begin
                for (int k = 0; k < 2000 && !found; k++) begin
                    @(negedge Clk);
                    if (wr_pulse === 1'b1) begin
                        loc_we = 1'b1; loc_addr = la; loc_wdata = 8'h99;
                        found = 1'b1;
                    end
                end
                @(negedge Clk);
                loc_we = 1'b0;
            end
        join
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL coll_pulse_seen: got %b want 1", found); end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        collide(5'd7, 8'h55);
        loc_read(5'd7, d);
        checks++; if (d !== 8'h55) begin errors++; $display("FAIL coll_same_reg7: got %h want 55", d); end
        collide(5'd8, 8'h66);
        loc_read(5'd7, d);
        checks++; if (d !== 8'h66) begin errors++; $display("FAIL coll_diff_reg7: got %h want 66", d); end
        loc_read(5'd8, d);
        checks++; if (d !== 8'h99) begin errors++; $display("FAIL coll_diff_reg8: got %h want 99", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic [7:0] d;
        int         pc0;
        ss_low();
        spi_byte(8'h18, rx);
        spi_bits(8'h00, 4, rx);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b want 0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b want 0", MISO_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        wait_clk(3);
        Reset_n = 1'b1;
        wait_clk(20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_rel_busy: got %b want 0", busy); end
        loc_read(5'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_reg3: got %h want 00", d); end
        ss_high();
        pc0 = pulse_cnt;
        ss_low();
        spi_byte(8'h52, rx);
        spi_byte(8'h3E, rx);
        ss_high();
        checks++; if (pulse_cnt - pc0 != 1) begin errors++; $display("FAIL rst_after_pulses: got %0d want 1", pulse_cnt - pc0); end
        checks++; if (last_data !== 8'h3E) begin errors++; $display("FAIL rst_after_data: got %h want 3e", last_data); end
        status = 8'hC3;
        ss_low();
        spi_byte(8'h50, rx);
        checks++; if (rx !== 8'hC3) begin errors++; $display("FAIL rst_after_status: got %h want c3", rx); end
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'h3E) begin errors++; $display("FAIL rst_after_read: got %h want 3e", rx); end
        ss_high();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_sclk_ignored();
        test_burst();
        test_abort();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
